fft_in_buf8: RTL and testbench
==============================

Name: fft_in_buf8

Overview:
Serial-to-parallel input stage directly upstream of the 8-point FFT core. Accepts one complex sample per cycle over a valid/ready handshake and collects 8-sample frames in bit-reversed slice order in a ping-pong buffer. Presents each complete frame as a packed 8-lane bus, together with the four constant W8 twiddles, using a valid/ready handshake on the output side.

Parameters:
DATA_INP_WD, 16, width of each re/im sample; must equal the core's DATA_INP_WD.
(`CFG_WN_WD and `DATA_FRA_WD come from fft_defines.vh and are not parameters.)

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
dat_vld_i  input  1  input sample valid
dat_rdy_o  output  1  block can accept a sample
dat_sop_i  input  1  current sample is frame index 0; qualified by dat_vld_i
dat_re_i  input  DATA_INP_WD  sample real part, two's complement
dat_im_i  input  DATA_INP_WD  sample imaginary part
fft_vld_o  output  1  complete frame presented
fft_rdy_i  input  1  downstream consumes the frame
fft_dat_re_o  output  8*DATA_INP_WD  packed real parts, lane 0 in MSB slice
fft_dat_im_o  output  8*DATA_INP_WD  packed imaginary parts
fft_wn_re_o  output  4*`CFG_WN_WD  W8^0..W8^3 real parts, W8^0 in MSB slice
fft_wn_im_o  output  4*`CFG_WN_WD  W8^0..W8^3 imaginary parts
frm_err_o  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous, active-low, on rstn.
  - In reset, every register clears to 0: both banks, both full flags, write index, write bank and read bank.
  - Resulting output reset values: dat_rdy_o=1, fft_vld_o=0, fft_dat_*_o=0, frm_err_o=0.
  - Twiddle outputs are constants and are never affected by reset.
- Input transfer:
  - A sample is accepted when dat_vld_i & dat_rdy_o.
  - dat_rdy_o = !full[wr_bank]. It is a pure function of registered state, with no combinational path from fft_rdy_i.
- Bit-reversed lane placement:
  - Sample with in-frame index n (3-bit wr_idx) is written to lane bitrev3(n).
  - Lane order 0..7 therefore holds x0,x4,x2,x6,x1,x5,x3,x7.
  - Lane k occupies bits [(8-k)*W-1 : (7-k)*W], where W = DATA_INP_WD.
- Frame completion:
  - wr_idx increments on each accept.
  - Accepting index 7 sets full[wr_bank], toggles wr_bank and wraps wr_idx to 0.
- Resync on dat_sop_i:
  - An accepted sample with dat_sop_i=1 forces in-frame index 0: it is written to lane 0 and wr_idx becomes 1.
  - If wr_idx was nonzero at that point, the partial frame is abandoned and frm_err_o pulses high for one cycle, registered on the cycle after the accept.
  - dat_sop_i is ignored when not accepted.
  - dat_sop_i on an accept at wr_idx=0 is normal and raises no error.
- Output handshake:
  - fft_vld_o = full[rd_bank].
  - fft_dat_*_o are driven directly from bank rd_bank, with no extra register stage.
  - On fft_vld_o & fft_rdy_i: clear full[rd_bank] and toggle rd_bank.
  - Output data stays stable while fft_vld_o=1 and fft_rdy_i=0.
- Latency: the 8th sample accepted at edge N gives fft_vld_o=1 after edge N, so it is visible in cycle N+1.
- Throughput: with fft_rdy_i held at 1, input runs at 1 sample/clk with no bubbles. One frame is output every 8 cycles.
- Simultaneous events:
  - Completing a frame in one bank while the other bank is read in the same cycle is legal; both flag updates apply.
  - With both banks full, dat_rdy_o=0. A read in that cycle raises dat_rdy_o in the next cycle, never in the same cycle.
- Reset mid-frame: partial data is discarded and no frm_err_o is raised.
- Twiddles:
  - W8^k = cos(2πk/8) - j·sin(2πk/8), quantised to `CFG_WN_WD bits with `DATA_FRA_WD fraction bits, round-to-nearest.
  - Magnitude 1.0 is coded as 2^`DATA_FRA_WD; this requires `CFG_WN_WD ≥ `DATA_FRA_WD+2.
  - Values:
    - W0 = (1, 0)
    - W1 = (c, -c)
    - W2 = (0, -1)
    - W3 = (-c, -c)
    - c = round(0.70710678 · 2^`DATA_FRA_WD).

Decomposition:
- Add to fft_defines.vh:
  - `FFT8_WN{0..3}_RE and `FFT8_WN{0..3}_IM constant macros.
  - A 3-bit bit-reverse function macro, or a shared function include.
- One sub-module is natural: fft_in_bank8, a single 8-lane register bank with a write-lane select and a packed read-out. Instantiate it twice for the ping-pong.
- Handshake logic and pointers stay in the top level.

Test Plan:
1. Reset, then stream samples re=n, im=-n for n=0..7 with fft_rdy_i=1 → fft_vld_o high one cycle after the 8th accept. Lanes 0..7 re = 0,4,2,6,1,5,3,7; im negated.
2. Hold fft_rdy_i=0 and stream 24 samples → after 16 accepts dat_rdy_o=0. First frame data is stable throughout the stall. Raise fft_rdy_i → the two frames come out in order, and dat_rdy_o returns 1 the cycle after the first read.
3. Continuous streaming for 64 samples with fft_rdy_i=1 → 8 frames, dat_rdy_o never drops, fft_vld_o pulses once every 8 cycles.
4. Accept 3 samples, then a sample with dat_sop_i=1 and value 100 → frm_err_o pulses once. The next frame's lane 0 = 100 and contains only post-sop samples.
5. Assert rstn=0 after 5 samples, then release → fft_vld_o=0 and frm_err_o=0. The next 8 samples form a clean frame.
6. With `DATA_FRA_WD=14 → fft_wn_re_o lanes = 16384, 11585, 0, -11585; fft_wn_im_o lanes = 0, -11585, -16384, -11585.

Source files
------------

// File: rtl/fft_in_buf8_pkg.sv
// fft_in_buf8_pkg
// Shared constants for the 8-point FFT input stage: twiddle word format,
// W8 twiddle constants and the 3-bit bit-reverse helper.
// The macro block below carries the fft_defines.vh content so that every
// file in the slice sees the same definitions; each macro is guarded so
// an existing project-wide fft_defines.vh takes precedence.

`ifndef CFG_WN_WD
`define CFG_WN_WD 16
`endif

`ifndef DATA_FRA_WD
`define DATA_FRA_WD 14
`endif

// round(0.70710678 * 2^DATA_FRA_WD): 3037000500 is 1/sqrt(2) scaled by 2^32.
// Adding 2^31 before the shift gives round-to-nearest.
`ifndef FFT8_C
`define FFT8_C ((((64'd3037000500) << `DATA_FRA_WD) + 64'd2147483648) >> 32)
`endif

`ifndef FFT8_ONE
`define FFT8_ONE (64'd1 << `DATA_FRA_WD)
`endif

`ifndef FFT8_WN0_RE
`define FFT8_WN0_RE (`CFG_WN_WD'(`FFT8_ONE))
`define FFT8_WN0_IM (`CFG_WN_WD'(0))
`define FFT8_WN1_RE (`CFG_WN_WD'(`FFT8_C))
`define FFT8_WN1_IM (`CFG_WN_WD'(64'd0 - `FFT8_C))
`define FFT8_WN2_RE (`CFG_WN_WD'(0))
`define FFT8_WN2_IM (`CFG_WN_WD'(64'd0 - `FFT8_ONE))
`define FFT8_WN3_RE (`CFG_WN_WD'(64'd0 - `FFT8_C))
`define FFT8_WN3_IM (`CFG_WN_WD'(64'd0 - `FFT8_C))
`endif

`ifndef FFT8_BITREV3
`define FFT8_BITREV3(n) {n[0], n[1], n[2]}
`endif

package fft_in_buf8_pkg;

   localparam int WN_WD  = `CFG_WN_WD;
   localparam int FRA_WD = `DATA_FRA_WD;
   localparam int LANES  = 8;

   typedef logic [2:0] lane_idx_t;

   function automatic lane_idx_t bitrev3(input lane_idx_t n);
      return `FFT8_BITREV3(n);
   endfunction

endpackage

// File: rtl/fft_in_buf8_bank.sv
// fft_in_bank8
// One 8-lane complex register bank. A single lane is written per cycle
// under wr_en_i; all lanes are continuously presented on packed buses.
// Ports:
//   clk, rstn          clock, synchronous active-low reset (clears all lanes)
//   wr_en_i            write strobe
//   wr_lane_i          lane to write (0..7)
//   wr_re_i, wr_im_i   sample to store
//   rd_re_o, rd_im_o   packed read-out, lane 0 in the MSB slice

module fft_in_bank8
   import fft_in_buf8_pkg::*;
#(
   parameter int DATA_INP_WD = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         wr_en_i,
   input  logic [2:0]                   wr_lane_i,
   input  logic [DATA_INP_WD-1:0]       wr_re_i,
   input  logic [DATA_INP_WD-1:0]       wr_im_i,
   output logic [LANES*DATA_INP_WD-1:0] rd_re_o,
   output logic [LANES*DATA_INP_WD-1:0] rd_im_o
);

   logic [DATA_INP_WD-1:0] lane_re_q [LANES];
   logic [DATA_INP_WD-1:0] lane_im_q [LANES];
   logic [DATA_INP_WD-1:0] lane_re_d [LANES];
   logic [DATA_INP_WD-1:0] lane_im_d [LANES];

   always_comb begin
      lane_re_d = lane_re_q;
      lane_im_d = lane_im_q;
      if (wr_en_i) begin
         lane_re_d[wr_lane_i] = wr_re_i;
         lane_im_d[wr_lane_i] = wr_im_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 0; k < LANES; k++) begin
            lane_re_q[k] <= '0;
            lane_im_q[k] <= '0;
         end
      end else begin
         lane_re_q <= lane_re_d;
         lane_im_q <= lane_im_d;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_pack
      assign rd_re_o[(LANES-k)*DATA_INP_WD-1 -: DATA_INP_WD] = lane_re_q[k];
      assign rd_im_o[(LANES-k)*DATA_INP_WD-1 -: DATA_INP_WD] = lane_im_q[k];
   end

endmodule

// File: rtl/fft_in_buf8.sv
// fft_in_buf8
// Serial-to-parallel input stage for the 8-point FFT core. Collects
// 8-sample complex frames in bit-reversed lane order into a ping-pong pair
// of banks and presents each complete frame as a packed 8-lane bus with the
// constant W8^0..W8^3 twiddles.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   dat_vld_i / dat_rdy_o        input sample handshake
//   dat_sop_i                    sample is frame index 0 (qualified by accept)
//   dat_re_i, dat_im_i           input sample
//   fft_vld_o / fft_rdy_i        output frame handshake
//   fft_dat_re_o, fft_dat_im_o   packed frame, lane 0 in the MSB slice
//   fft_wn_re_o, fft_wn_im_o     W8^0..W8^3 constants, W8^0 in the MSB slice
//   frm_err_o                    one-cycle pulse when a partial frame is dropped
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge. Ready never depends combinationally on valid,
// and dat_rdy_o depends only on registered state (not on fft_rdy_i), so a
// read that frees a bank raises dat_rdy_o one cycle later.

module fft_in_buf8
   import fft_in_buf8_pkg::*;
#(
   parameter int DATA_INP_WD = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         dat_vld_i,
   output logic                         dat_rdy_o,
   input  logic                         dat_sop_i,
   input  logic [DATA_INP_WD-1:0]       dat_re_i,
   input  logic [DATA_INP_WD-1:0]       dat_im_i,
   output logic                         fft_vld_o,
   input  logic                         fft_rdy_i,
   output logic [LANES*DATA_INP_WD-1:0] fft_dat_re_o,
   output logic [LANES*DATA_INP_WD-1:0] fft_dat_im_o,
   output logic [4*WN_WD-1:0]           fft_wn_re_o,
   output logic [4*WN_WD-1:0]           fft_wn_im_o,
   output logic                         frm_err_o
);

   logic [2:0] wr_idx_q, wr_idx_d;
   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic [1:0] full_q, full_d;
   logic       frm_err_q, frm_err_d;

   logic       accept;
   logic       rd_fire;
   lane_idx_t  idx_eff;
   lane_idx_t  wr_lane;

   logic [LANES*DATA_INP_WD-1:0] bank_re [2];
   logic [LANES*DATA_INP_WD-1:0] bank_im [2];

   always_comb begin
      dat_rdy_o = !full_q[wr_bank_q];
      fft_vld_o = full_q[rd_bank_q];
      accept    = dat_vld_i & dat_rdy_o;
      rd_fire   = fft_vld_o & fft_rdy_i;
      // A start-of-packet sample always lands at index 0, dropping any partial frame.
      idx_eff   = dat_sop_i ? 3'd0 : wr_idx_q;
      wr_lane   = bitrev3(idx_eff);

      full_d    = full_q;
      wr_idx_d  = wr_idx_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      frm_err_d = 1'b0;

      // A read and a write completion in the same cycle always target
      // different banks (write needs !full, read needs full), so both
      // flag updates can be applied independently.
      if (rd_fire) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end

      if (accept) begin
         wr_idx_d  = idx_eff + 3'd1;
         frm_err_d = dat_sop_i && (wr_idx_q != 3'd0);
         if (idx_eff == 3'd7) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_idx_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         frm_err_q <= 1'b0;
      end else begin
         wr_idx_q  <= wr_idx_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         frm_err_q <= frm_err_d;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_in_bank8 #(
         .DATA_INP_WD (DATA_INP_WD)
      ) u_bank (
         .clk       (clk),
         .rstn      (rstn),
         .wr_en_i   (accept && (wr_bank_q == 1'(b))),
         .wr_lane_i (wr_lane),
         .wr_re_i   (dat_re_i),
         .wr_im_i   (dat_im_i),
         .rd_re_o   (bank_re[b]),
         .rd_im_o   (bank_im[b])
      );
   end

   assign fft_dat_re_o = rd_bank_q ? bank_re[1] : bank_re[0];
   assign fft_dat_im_o = rd_bank_q ? bank_im[1] : bank_im[0];
   assign frm_err_o    = frm_err_q;

   assign fft_wn_re_o = {`FFT8_WN0_RE, `FFT8_WN1_RE, `FFT8_WN2_RE, `FFT8_WN3_RE};
   assign fft_wn_im_o = {`FFT8_WN0_IM, `FFT8_WN1_IM, `FFT8_WN2_IM, `FFT8_WN3_IM};

endmodule

// File: tb/tb_fft_in_buf8.sv
// Testbench for fft_in_buf8: random and directed stimulus checked against a
// frame-level reference model (queue of expected frames).

module tb_fft_in_buf8;
   import fft_in_buf8_pkg::*;

   localparam int W = 16;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             dat_vld_i = 1'b0;
   logic             dat_rdy_o;
   logic             dat_sop_i = 1'b0;
   logic [W-1:0]     dat_re_i = '0;
   logic [W-1:0]     dat_im_i = '0;
   logic             fft_vld_o;
   logic             fft_rdy_i = 1'b0;
   logic [8*W-1:0]   fft_dat_re_o;
   logic [8*W-1:0]   fft_dat_im_o;
   logic [4*WN_WD-1:0] fft_wn_re_o;
   logic [4*WN_WD-1:0] fft_wn_im_o;
   logic             frm_err_o;

   fft_in_buf8 #(.DATA_INP_WD(W)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .dat_vld_i    (dat_vld_i),
      .dat_rdy_o    (dat_rdy_o),
      .dat_sop_i    (dat_sop_i),
      .dat_re_i     (dat_re_i),
      .dat_im_i     (dat_im_i),
      .fft_vld_o    (fft_vld_o),
      .fft_rdy_i    (fft_rdy_i),
      .fft_dat_re_o (fft_dat_re_o),
      .fft_dat_im_o (fft_dat_im_o),
      .fft_wn_re_o  (fft_wn_re_o),
      .fft_wn_im_o  (fft_wn_im_o),
      .frm_err_o    (frm_err_o)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard / model ----------------
   int n_pass  = 0;
   int n_total = 0;
   int frames_out = 0;
   int err_seen   = 0;
   int accepts    = 0;
   logic err_exp  = 1'b0;

   logic [8*W-1:0] exp_re_q[$];
   logic [8*W-1:0] exp_im_q[$];
   logic [W-1:0]   cur_re[$];
   logic [W-1:0]   cur_im[$];

   function automatic logic [2:0] rev3(input logic [2:0] n);
      logic [2:0] r;
      for (int b = 0; b < 3; b++) r[b] = n[2-b];
      return r;
   endfunction

   // Frame model: samples are gathered in arrival order; a completed frame
   // is packed with sample index n placed in lane rev3(n).
   task automatic model_accept(input logic sop, input logic [W-1:0] re, input logic [W-1:0] im);
      logic [8*W-1:0] fr, fi;
      if (sop) begin
         if (cur_re.size() != 0) err_exp = 1'b1;
         cur_re.delete();
         cur_im.delete();
      end
      cur_re.push_back(re);
      cur_im.push_back(im);
      if (cur_re.size() == 8) begin
         fr = '0;
         fi = '0;
         for (int n = 0; n < 8; n++) begin
            fr[(8-int'(rev3(3'(n))))*W-1 -: W] = cur_re[n];
            fi[(8-int'(rev3(3'(n))))*W-1 -: W] = cur_im[n];
         end
         exp_re_q.push_back(fr);
         exp_im_q.push_back(fi);
         cur_re.delete();
         cur_im.delete();
      end
   endtask

   // One clock cycle with inputs already driven; observes at the negedge.
   task automatic tick();
      logic acc, fire;
      acc  = dat_vld_i && dat_rdy_o;
      fire = fft_vld_o && fft_rdy_i;

      n_total++;
      if (dat_rdy_o !== (exp_re_q.size() < 2))
         $display("FAIL dat_rdy_o: got %b want %b", dat_rdy_o, exp_re_q.size() < 2);
      else n_pass++;

      n_total++;
      if (fft_vld_o !== (exp_re_q.size() != 0))
         $display("FAIL fft_vld_o: got %b want %b", fft_vld_o, exp_re_q.size() != 0);
      else n_pass++;

      if (fft_vld_o && exp_re_q.size() != 0) begin
         n_total++;
         if (fft_dat_re_o !== exp_re_q[0] || fft_dat_im_o !== exp_im_q[0])
            $display("FAIL frame_data: got re=%h im=%h want re=%h im=%h",
                     fft_dat_re_o, fft_dat_im_o, exp_re_q[0], exp_im_q[0]);
         else n_pass++;
      end

      if (fire && exp_re_q.size() != 0) begin
         void'(exp_re_q.pop_front());
         void'(exp_im_q.pop_front());
         frames_out++;
      end
      if (acc) begin
         accepts++;
         model_accept(dat_sop_i, dat_re_i, dat_im_i);
      end

      @(posedge clk);
      @(negedge clk);

      n_total++;
      if (frm_err_o !== err_exp)
         $display("FAIL frm_err_o: got %b want %b", frm_err_o, err_exp);
      else n_pass++;
      if (frm_err_o === 1'b1) err_seen++;
      err_exp = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic vld, input logic sop, input logic [W-1:0] re,
                       input logic [W-1:0] im, input logic rdy);
      dat_vld_i = vld;
      dat_sop_i = sop;
      dat_re_i  = re;
      dat_im_i  = im;
      fft_rdy_i = rdy;
      tick();
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) send(1'b0, 1'b0, '0, '0, rdy);
   endtask

   task automatic apply_reset();
      rstn      = 1'b0;
      dat_vld_i = 1'b0;
      dat_sop_i = 1'b0;
      fft_rdy_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      exp_re_q.delete();
      exp_im_q.delete();
      cur_re.delete();
      cur_im.delete();
      err_exp = 1'b0;
   endtask

   task automatic release_reset();
      rstn = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      n_total++;
      if (dat_rdy_o !== 1'b1) $display("FAIL reset_rdy: got %b want 1", dat_rdy_o); else n_pass++;
      n_total++;
      if (fft_vld_o !== 1'b0) $display("FAIL reset_vld: got %b want 0", fft_vld_o); else n_pass++;
      n_total++;
      if (fft_dat_re_o !== '0 || fft_dat_im_o !== '0)
         $display("FAIL reset_data: got re=%h im=%h want 0", fft_dat_re_o, fft_dat_im_o);
      else n_pass++;
      n_total++;
      if (frm_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", frm_err_o); else n_pass++;
      release_reset();
   endtask

   task automatic test_basic();
      logic [8*W-1:0] want_re;
      int lane_vals[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int n = 0; n < 8; n++) send(1'b1, n == 0, W'(n), W'(-n), 1'b0);
      // Visible in the cycle after the 8th accept, with explicit lane order.
      for (int k = 0; k < 8; k++) want_re[(8-k)*W-1 -: W] = W'(lane_vals[k]);
      n_total++;
      if (fft_vld_o !== 1'b1 || fft_dat_re_o !== want_re)
         $display("FAIL basic_lanes: got vld=%b re=%h want vld=1 re=%h", fft_vld_o, fft_dat_re_o, want_re);
      else n_pass++;
      idle(3, 1'b1);
   endtask

   task automatic test_stall();
      int acc0;
      acc0 = accepts;
      for (int n = 0; n < 24; n++) send(1'b1, 1'b0, W'($urandom), W'($urandom), 1'b0);
      n_total++;
      if (accepts - acc0 != 16) $display("FAIL stall_accepts: got %0d want 16", accepts - acc0); else n_pass++;
      idle(5, 1'b1);
   endtask

   task automatic test_stream();
      int f0, a0;
      f0 = frames_out;
      a0 = accepts;
      for (int n = 0; n < 64; n++) send(1'b1, (n % 8) == 0, W'($urandom), W'($urandom), 1'b1);
      idle(2, 1'b1);
      n_total++;
      if (accepts - a0 != 64) $display("FAIL stream_accepts: got %0d want 64", accepts - a0); else n_pass++;
      n_total++;
      if (frames_out - f0 != 8) $display("FAIL stream_frames: got %0d want 8", frames_out - f0); else n_pass++;
   endtask

   task automatic test_sop();
      int e0, f0;
      e0 = err_seen;
      f0 = frames_out;
      for (int n = 0; n < 3; n++) send(1'b1, n == 0, W'(10 + n), W'(20 + n), 1'b1);
      send(1'b1, 1'b1, W'(100), W'(200), 1'b1);
      for (int n = 1; n < 8; n++) send(1'b1, 1'b0, W'(100 + n), W'(200 + n), 1'b0);
      n_total++;
      if (fft_dat_re_o[8*W-1 -: W] !== W'(100))
         $display("FAIL sop_lane0: got %0d want 100", fft_dat_re_o[8*W-1 -: W]);
      else n_pass++;
      idle(2, 1'b1);
      n_total++;
      if (err_seen - e0 != 1) $display("FAIL sop_err_count: got %0d want 1", err_seen - e0); else n_pass++;
      n_total++;
      if (frames_out - f0 != 1) $display("FAIL sop_frames: got %0d want 1", frames_out - f0); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int f0;
      for (int n = 0; n < 5; n++) send(1'b1, n == 0, W'($urandom), W'($urandom), 1'b1);
      apply_reset();
      release_reset();
      @(posedge clk);
      @(negedge clk);
      n_total++;
      if (fft_vld_o !== 1'b0 || frm_err_o !== 1'b0)
         $display("FAIL reset_mid: got vld=%b err=%b want 0 0", fft_vld_o, frm_err_o);
      else n_pass++;
      f0 = frames_out;
      for (int n = 0; n < 8; n++) send(1'b1, 1'b0, W'(n + 50), W'(n + 60), 1'b1);
      idle(2, 1'b1);
      n_total++;
      if (frames_out - f0 != 1) $display("FAIL reset_mid_frames: got %0d want 1", frames_out - f0); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         send($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
              W'($urandom), W'($urandom), $urandom_range(0, 2) != 0);
      idle(6, 1'b1);
      n_total++;
      if (exp_re_q.size() != 0) $display("FAIL random_drain: got %0d left want 0", exp_re_q.size()); else n_pass++;
   endtask

   task automatic test_twiddle();
      int c;
      int one;
      int want_re[4];
      int want_im[4];
      one = 1 << FRA_WD;
      c = $rtoi(0.70710678 * (2.0 ** FRA_WD) + 0.5);
      want_re = '{one, c, 0, -c};
      want_im = '{0, -c, -one, -c};
      for (int k = 0; k < 4; k++) begin
         n_total++;
         if (fft_wn_re_o[(4-k)*WN_WD-1 -: WN_WD] !== WN_WD'(want_re[k]))
            $display("FAIL wn_re%0d: got %0d want %0d", k,
                     $signed(fft_wn_re_o[(4-k)*WN_WD-1 -: WN_WD]), want_re[k]);
         else n_pass++;
         n_total++;
         if (fft_wn_im_o[(4-k)*WN_WD-1 -: WN_WD] !== WN_WD'(want_im[k]))
            $display("FAIL wn_im%0d: got %0d want %0d", k,
                     $signed(fft_wn_im_o[(4-k)*WN_WD-1 -: WN_WD]), want_im[k]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_twiddle();
      test_basic();
      test_stall();
      test_stream();
      test_sop();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
